// File: rtl/mul_seq_param.sv
// Iterative shift-add multiplier, K multiplier bits per cycle, signed/unsigned per operation.
// Latency: fin pulses N=WB/K cycles after the start edge. start is ignored while busy (no queueing).
// Optional MUL_ACC_EN: O = A*B + C, with C added in the final step.
module mul_seq_param #(
    parameter int WA = 16,
    parameter int WB = 16,
    parameter int K  = 1
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WA-1:0]    A,
    input  logic [WB-1:0]    B,
    input  logic [WA+WB-1:0] C,
    output logic [WA+WB:0]   O,
    output logic             busy,
    output logic             fin
);
    localparam int W  = WA + WB + 1;
    localparam int N  = WB / K;
    localparam int CW = $clog2(N) + 1;

    generate
        if (K < 1 || (WB % K) != 0) begin : g_bad_k
            $error("mul_seq_param: K must divide WB");
        end
        if (WA < 2 || WB < 2) begin : g_bad_w
            $error("mul_seq_param: WA and WB must be >= 2");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [W-1:0]   a_r;
    logic [WB-1:0]  b_r;
    logic [W-1:0]   acc;
    logic [CW-1:0]  cnt;
    logic           sgn_r;

    logic [K-1:0]   grp;
    logic [W-1:0]   grp_ext;
    logic [W-1:0]   prod;
    logic [W-1:0]   acc_nxt;
    logic [W-1:0]   result;
    logic           last;

    // Only the first (most significant) group carries negative weight in signed mode.
    assign grp     = b_r[WB-1 -: K];
    assign grp_ext = (sgn_r && cnt == '0) ? {{(W-K){grp[K-1]}}, grp}
                                          : {{(W-K){1'b0}}, grp};
    // Modulo-2^W arithmetic is exact because the final value always fits in W bits.
    assign prod    = a_r * grp_ext;
    assign acc_nxt = (acc << K) + prod;
    assign last    = (cnt == CW'(N - 1));

`ifdef MUL_ACC_EN
    logic [W-1:0] c_r;
    assign result = acc_nxt + c_r;
`else
    logic unused_c;
    assign unused_c = ^C;
    assign result   = acc_nxt;
`endif

    always_ff @(posedge ck) begin
        if (rst) begin
            state <= IDLE;
            O     <= '0;
            busy  <= 1'b0;
            fin   <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            sgn_r <= 1'b0;
`ifdef MUL_ACC_EN
            c_r   <= '0;
`endif
        end else begin
            fin <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= sgn ? {{(WB+1){A[WA-1]}}, A} : {{(WB+1){1'b0}}, A};
                        b_r   <= B;
                        sgn_r <= sgn;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef MUL_ACC_EN
                        c_r   <= sgn ? {C[WA+WB-1], C} : {1'b0, C};
`endif
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    b_r <= b_r << K;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        O     <= result;
                        fin   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_param.sv
// Directed bench for mul_seq_param: table of operations on a 16x16/K=1 instance,
// plus hand sequences for handshake, reset abort and a K=4 instance.
module tb_mul_seq_param;
    logic        ck = 1'b0;
    logic        rst;
    logic        start, sgn;
    logic [15:0] A, B;
    logic [31:0] C;
    logic [32:0] O;
    logic        busy, fin;

    logic        start4;
    logic [32:0] O4;
    logic        busy4, fin4;

    int checks = 0;
    int errors = 0;

    always #5 ck = ~ck;

    mul_seq_param #(.WA(16), .WB(16), .K(1)) dut (
        .ck(ck), .rst(rst), .start(start), .sgn(sgn), .A(A), .B(B), .C(C),
        .O(O), .busy(busy), .fin(fin)
    );

    mul_seq_param #(.WA(16), .WB(16), .K(4)) dut4 (
        .ck(ck), .rst(rst), .start(start4), .sgn(sgn), .A(A), .B(B), .C(C),
        .O(O4), .busy(busy4), .fin(fin4)
    );

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
        logic [32:0] ab;   // expected A*B alone
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [32:0] with_c(input logic s, input logic [32:0] ab, input logic [31:0] c);
`ifdef MUL_ACC_EN
        logic [32:0] ce;
        ce = s ? {c[31], c} : {1'b0, c};
        return ab + ce;
`else
        return ab;
`endif
    endfunction

    // Launch on the 16x16/K=1 instance; lat = edges from the start edge to fin.
    task automatic do_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] c, output logic [32:0] o, output int lat);
        @(negedge ck);
        sgn = s; A = a; B = b; C = c; start = 1'b1;
        @(posedge ck); #1;
        start = 1'b0;
        chk("busy_after_start", {32'd0, busy}, 33'd1);
        lat = 0;
        while (!fin && lat < 100) begin
            @(posedge ck); #1;
            lat++;
        end
        o = O;
    endtask

    task automatic do_op4(input logic s, input logic [15:0] a, input logic [15:0] b,
                          output logic [32:0] o, output int lat);
        @(negedge ck);
        sgn = s; A = a; B = b; C = 32'd0; start4 = 1'b1;
        @(posedge ck); #1;
        start4 = 1'b0;
        lat = 0;
        while (!fin4 && lat < 100) begin
            @(posedge ck); #1;
            lat++;
        end
        o = O4;
    endtask

    initial begin
        logic [32:0] o;
        int          lat;
        int          nfin;

        tbl[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'd0,          33'h0FFFE0001};
        tbl[1] = '{1'b1, 16'h8000, 16'h8000, 32'd0,          33'h040000000};
        tbl[2] = '{1'b1, 16'hFFFF, 16'h0003, 32'd0,          33'h1FFFFFFFD};
        tbl[3] = '{1'b0, 16'd1234, 16'd5678, 32'd0,          33'd7006652};
        tbl[4] = '{1'b1, 16'h0000, 16'h8123, 32'd0,          33'd0};
        tbl[5] = '{1'b1, 16'h7FFF, 16'h8000, 32'd0,          33'h1C0008000};
        tbl[6] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'd0,          33'd1};
        tbl[7] = '{1'b1, 16'h0005, 16'hFFFE, 32'd0,          33'h1FFFFFFF6};
        tbl[8] = '{1'b0, 16'h8000, 16'h0002, 32'h0000_1234,  33'h000010000};

        rst = 1'b1; start = 1'b0; start4 = 1'b0; sgn = 1'b0;
        A = '0; B = '0; C = '0;
        repeat (3) @(posedge ck);
        #1;
        chk("reset_O", O, 33'd0);
        chk("reset_busy", {32'd0, busy}, 33'd0);
        chk("reset_fin", {32'd0, fin}, 33'd0);
        @(negedge ck);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c, o, lat);
            chk($sformatf("vec%0d_O", i), o, with_c(tbl[i].s, tbl[i].ab, tbl[i].c));
            chk($sformatf("vec%0d_lat", i), 33'(lat), 33'd16);
        end

`ifdef MUL_ACC_EN
        do_op(1'b0, 16'd3, 16'd5, 32'd7, o, lat);
        chk("acc_unsigned", o, 33'd22);
        do_op(1'b1, 16'd3, 16'd5, 32'hFFFF_FFE2, o, lat);
        chk("acc_signed", o, 33'h1FFFFFFF1);
`else
        do_op(1'b0, 16'd3, 16'd5, 32'd7, o, lat);
        chk("c_ignored", o, 33'd15);
`endif

        // Starts mid-run ignored; start in the fin cycle launches back-to-back.
        @(negedge ck);
        sgn = 1'b0; A = 16'hFFFF; B = 16'hFFFF; C = '0; start = 1'b1;
        @(posedge ck); #1;
        start = 1'b0;
        nfin = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge ck);
            if (i == 3 || i == 7) begin
                start = 1'b1; A = 16'd1; B = 16'd1;
            end else if (i == 17) begin
                start = 1'b1; A = 16'd2; B = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge ck); #1;
            if (fin) nfin++;
            if (i == 16) begin
                chk("hs_fin16", {32'd0, fin}, 33'd1);
                chk("hs_O16", O, 33'h0FFFE0001);
            end
            if (i == 20) chk("hs_O_hold", O, 33'h0FFFE0001);
            if (i == 33) begin
                chk("b2b_fin33", {32'd0, fin}, 33'd1);
                chk("b2b_O33", O, 33'd6);
            end
        end
        start = 1'b0;
        chk("hs_fin_count", 33'(nfin), 33'd2);

        // Reset aborts an operation in flight.
        @(negedge ck);
        sgn = 1'b0; A = 16'd7; B = 16'd9; start = 1'b1;
        @(posedge ck); #1;
        start = 1'b0;
        repeat (7) @(posedge ck);
        @(negedge ck);
        rst = 1'b1;
        @(posedge ck); #1;
        chk("abort_busy", {32'd0, busy}, 33'd0);
        chk("abort_fin", {32'd0, fin}, 33'd0);
        chk("abort_O", O, 33'd0);
        @(negedge ck);
        rst = 1'b0;
        nfin = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge ck); #1;
            if (fin) nfin++;
        end
        chk("abort_no_fin", 33'(nfin), 33'd0);

        // K=4 instance: 4-step latency.
        do_op4(1'b0, 16'd1234, 16'd5678, o, lat);
        chk("k4_O", o, 33'd7006652);
        chk("k4_lat", 33'(lat), 33'd4);
        do_op4(1'b1, 16'hFFFD, 16'hFFF9, o, lat);
        chk("k4_signed_O", o, 33'd21);
        chk("k4_signed_lat", 33'(lat), 33'd4);
        do_op4(1'b1, 16'h8000, 16'h8000, o, lat);
        chk("k4_minmin_O", o, 33'h040000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
